di_frame_capture_ctrl: RTL and testbench



---
 rtl/di_rx_pkg.sv | 28 ++
 rtl/di_frame_capture_ctrl_if.sv | 33 +++
 rtl/di_sync_fifo.sv | 72 +++++++
 rtl/di_frame_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_di_frame_capture_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/di_rx_pkg.sv
// -----------------------------------------------------------------------------
// di_rx_pkg
// Types and constants shared by the DI/DID receive capture path.
//   state_e : capture sequencer states (IDLE / HUNT / CAPTURE)
//   beat_t  : one buffered beat, {DI,DID} data plus start/end-of-frame tags
//   DEFAULT_* : default build values for the capture controller parameters
// No ports (package). No configuration macros.
// -----------------------------------------------------------------------------
package di_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } beat_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD  = 8'hA5;
  localparam int         DEFAULT_SYNC_CNT   = 2;
  localparam int         DEFAULT_FRAME_LEN  = 256;
  localparam int         DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/di_frame_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// di_frame_capture_ctrl_if
// Bundles the receive byte pair and the downstream valid/ready beat stream.
//   DI, DID    : receive bytes from the differential input buffers
//   DOUT       : {DI,DID} beat, DI in [15:8]
//   DOUT_SOF   : first beat of a frame
//   DOUT_EOF   : last beat of a frame
//   DOUT_VLD   : DOUT holds a beat
//   DOUT_RDY   : downstream accepts the beat
// Modports: master = receive source / downstream sink side, slave = controller.
// No configuration macros.
// -----------------------------------------------------------------------------
interface di_frame_capture_ctrl_if;

  logic [7:0]  DI;
  logic [7:0]  DID;
  logic [15:0] DOUT;
  logic        DOUT_SOF;
  logic        DOUT_EOF;
  logic        DOUT_VLD;
  logic        DOUT_RDY;

  modport master (
    output DI, DID, DOUT_RDY,
    input  DOUT, DOUT_SOF, DOUT_EOF, DOUT_VLD
  );

  modport slave (
    input  DI, DID, DOUT_RDY,
    output DOUT, DOUT_SOF, DOUT_EOF, DOUT_VLD
  );

endinterface

// File: rtl/di_sync_fifo.sv
// -----------------------------------------------------------------------------
// di_sync_fifo
// Show-ahead synchronous FIFO: the head entry is always visible on data_o,
// and pop_i retires it. Push and pop may occur in the same cycle, including
// when full (the pop frees the slot the push takes).
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write request and data; ignored when full without a pop
//   pop_i        : retire head entry; ignored when empty
//   data_o       : head entry
//   full_o/empty_o : occupancy flags
// DEPTH must be a power of two. No configuration macros.
// -----------------------------------------------------------------------------
module di_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign data_o  = mem_q[rdPtr_q];

  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/di_frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// di_frame_capture_ctrl
// Hunts for SYNC_CNT consecutive SYNC_WORD bytes on DI, then captures
// FRAME_LEN {DI,DID} beats into a show-ahead FIFO and forwards them over a
// valid/ready stream tagged with SOF/EOF. The source cannot stall: a beat
// arriving while the FIFO is full (and not draining) is dropped and OVF set.
//   QCLK    : sole clock
//   RST     : synchronous active-high reset, aborts any frame in flight
//   EN      : arm capture (level)
//   rxBus   : DI/DID in, DOUT/DOUT_SOF/DOUT_EOF/DOUT_VLD out, DOUT_RDY in
//   BUSY    : sequencer in HUNT or CAPTURE
//   OVF     : sticky drop flag, cleared when leaving IDLE
//   FRM_CNT : completed frames, wraps
//   CHK_ERR : one-cycle checksum-mismatch pulse
// Configuration macro DI_FRAME_CHKSUM_EN: when defined, the DI byte of the
// last beat is checked against the XOR of all earlier DI bytes of the frame;
// when undefined, CHK_ERR is tied low and no checksum logic exists.
// -----------------------------------------------------------------------------
module di_frame_capture_ctrl
  import di_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int         SYNC_CNT   = DEFAULT_SYNC_CNT,
  parameter int         FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int         FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          QCLK,
  input  logic                          RST,
  input  logic                          EN,
  di_frame_capture_ctrl_if.slave        rxBus,
  output logic                          BUSY,
  output logic                          OVF,
  output logic [15:0]                   FRM_CNT,
  output logic                          CHK_ERR
);

  localparam int              BW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0]   LAST_BEAT   = BW'(FRAME_LEN - 1);
  localparam logic [3:0]      SYNC_TARGET = 4'(SYNC_CNT);

  state_e        state_q, state_d;
  logic [3:0]    syncCnt_q, syncCnt_d;
  logic [BW-1:0] beatCnt_q, beatCnt_d;
  logic [15:0]   frmCnt_q, frmCnt_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic          isLast;
  logic          fifoFull;
  logic          fifoEmpty;
  beat_t         pushBeat;
  beat_t         headBeat;

  // Control registers; reset abandons any partial frame and clears the counters.
  always_ff @(posedge QCLK) begin
    if (RST) begin
      state_q   <= IDLE;
      syncCnt_q <= '0;
      beatCnt_q <= '0;
      frmCnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      syncCnt_q <= syncCnt_d;
      beatCnt_q <= beatCnt_d;
      frmCnt_q  <= frmCnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Sequencer: sync bytes only advance the hunt counter and are never pushed;
  // once locked every cycle is a payload beat until the EOF beat, and EN is
  // only looked at again at the frame boundary so a frame is never truncated.
  always_comb begin
    state_d   = state_q;
    syncCnt_d = syncCnt_q;
    beatCnt_d = beatCnt_q;
    frmCnt_d  = frmCnt_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    isLast    = (beatCnt_q == LAST_BEAT);
    pushBeat  = '{data: {rxBus.DI, rxBus.DID},
                  sof:  (beatCnt_q == '0),
                  eof:  isLast};

    case (state_q)
      IDLE: begin
        syncCnt_d = '0;
        if (EN) begin
          state_d = HUNT;
          ovf_d   = 1'b0;
        end
      end

      HUNT: begin
        if (!EN) begin
          state_d   = IDLE;
          syncCnt_d = '0;
        end else if (rxBus.DI == SYNC_WORD) begin
          syncCnt_d = syncCnt_q + 4'd1;
          if (syncCnt_q + 4'd1 == SYNC_TARGET) begin
            state_d   = CAPTURE;
            beatCnt_d = '0;
          end
        end else begin
          syncCnt_d = '0;
        end
      end

      CAPTURE: begin
        push      = 1'b1;
        beatCnt_d = beatCnt_q + 1'b1;
        if (isLast) begin
          beatCnt_d = '0;
          syncCnt_d = '0;
          frmCnt_d  = frmCnt_q + 16'd1;
          state_d   = EN ? HUNT : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A dropped beat is still counted towards the frame; only OVF records it.
    if (push && fifoFull && !pop) begin
      ovf_d = 1'b1;
    end
  end

  assign pop = !fifoEmpty && rxBus.DOUT_RDY;

  di_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (QCLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (pushBeat),
    .pop_i   (pop),
    .data_o  (headBeat),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Output fields are forced to zero while empty so stale storage never shows.
  assign rxBus.DOUT_VLD = !fifoEmpty;
  assign rxBus.DOUT     = fifoEmpty ? 16'h0000 : headBeat.data;
  assign rxBus.DOUT_SOF = !fifoEmpty && headBeat.sof;
  assign rxBus.DOUT_EOF = !fifoEmpty && headBeat.eof;

  assign BUSY    = (state_q != IDLE);
  assign OVF     = ovf_q;
  assign FRM_CNT = frmCnt_q;

`ifdef DI_FRAME_CHKSUM_EN
  logic [7:0] chkAcc_q, chkAcc_d;
  logic       chkErr_q, chkErr_d;

  // Running XOR restarts on the SOF beat; on the EOF beat the accumulator
  // holds beats 0..FRAME_LEN-2, which the last DI byte must match.
  always_comb begin
    chkAcc_d = chkAcc_q;
    chkErr_d = 1'b0;
    if (push) begin
      chkAcc_d = pushBeat.sof ? rxBus.DI : (chkAcc_q ^ rxBus.DI);
      if (pushBeat.eof) begin
        chkErr_d = (rxBus.DI != chkAcc_q);
      end
    end
  end

  // Checksum registers; the error flag is a single-cycle pulse.
  always_ff @(posedge QCLK) begin
    if (RST) begin
      chkAcc_q <= '0;
      chkErr_q <= 1'b0;
    end else begin
      chkAcc_q <= chkAcc_d;
      chkErr_q <= chkErr_d;
    end
  end

  assign CHK_ERR = chkErr_q;
`else
  assign CHK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_di_frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_di_frame_capture_ctrl
// Directed bench for di_frame_capture_ctrl with default parameters
// (SYNC_WORD=A5, SYNC_CNT=2, FRAME_LEN=256, FIFO_DEPTH=8). Inputs change 1ns
// after each rising edge; outputs are sampled at that same point.
// Honours DI_FRAME_CHKSUM_EN for the expected CHK_ERR value.
// -----------------------------------------------------------------------------
module tb_di_frame_capture_ctrl;

  logic        QCLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        BUSY;
  logic        OVF;
  logic [15:0] FRM_CNT;
  logic        CHK_ERR;

  int checks = 0;
  int errors = 0;

`ifdef DI_FRAME_CHKSUM_EN
  localparam logic EXP_BAD_CHK = 1'b1;
`else
  localparam logic EXP_BAD_CHK = 1'b0;
`endif

  di_frame_capture_ctrl_if rxBus ();

  di_frame_capture_ctrl dut (
    .QCLK    (QCLK),
    .RST     (RST),
    .EN      (EN),
    .rxBus   (rxBus),
    .BUSY    (BUSY),
    .OVF     (OVF),
    .FRM_CNT (FRM_CNT),
    .CHK_ERR (CHK_ERR)
  );

  // 100 MHz receive clock.
  always #5 QCLK = ~QCLK;

  // Advance one clock and land just after the edge for sampling and driving.
  task automatic tick();
    @(posedge QCLK);
    #1;
  endtask

  // Drive every bench-owned input in one go.
  task automatic applyStimulus(input logic en, input logic [7:0] di,
                               input logic [7:0] did, input logic rdy);
    EN             = en;
    rxBus.DI       = di;
    rxBus.DID      = did;
    rxBus.DOUT_RDY = rdy;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Head-of-stream comparison: valid, data and both tags.
  task automatic checkBeat(input string tag, input logic [15:0] data,
                           input logic sof, input logic eof);
    checkOutput({tag, ".vld"}, 16'(rxBus.DOUT_VLD), 16'd1);
    checkOutput({tag, ".dout"}, rxBus.DOUT, data);
    checkOutput({tag, ".sof"}, 16'(rxBus.DOUT_SOF), 16'(sof));
    checkOutput({tag, ".eof"}, 16'(rxBus.DOUT_EOF), 16'(eof));
  endtask

  // From IDLE: arm, then present two sync bytes so the next edge samples beat 0.
  task automatic armAndLock(input logic rdy);
    applyStimulus(1'b1, 8'h00, 8'h00, rdy);
    tick();
    applyStimulus(1'b1, 8'hA5, 8'h00, rdy);
    tick();
    tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst.vld", 16'(rxBus.DOUT_VLD), 16'd0);
    checkOutput("rst.dout", rxBus.DOUT, 16'h0000);
    checkOutput("rst.sof", 16'(rxBus.DOUT_SOF), 16'd0);
    checkOutput("rst.eof", 16'(rxBus.DOUT_EOF), 16'd0);
    checkOutput("rst.busy", 16'(BUSY), 16'd0);
    checkOutput("rst.ovf", 16'(OVF), 16'd0);
    checkOutput("rst.frm", FRM_CNT, 16'd0);
    checkOutput("rst.chk", 16'(CHK_ERR), 16'd0);
    RST = 1'b0;

    // ---------------- lock and capture, RDY=1 ----------------
    $display("[TB] lock and capture");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("lock.busy_hunt", 16'(BUSY), 16'd1);
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("lock.no_early_vld", 16'(rxBus.DOUT_VLD), 16'd0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = 8'(k);
      applyStimulus(1'b1, b, ~b, 1'b1);
      tick();
      checkBeat("lock.beat", {b, ~b}, k == 0, k == 255);
      if (k == 0) checkOutput("lock.frm_before", FRM_CNT, 16'd0);
    end
    checkOutput("lock.frm", FRM_CNT, 16'd1);
    checkOutput("lock.busy_rehunt", 16'(BUSY), 16'd1);
    checkOutput("lock.chk_good", 16'(CHK_ERR), 16'd0);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("lock.drained", 16'(rxBus.DOUT_VLD), 16'd0);
    checkOutput("lock.chk_after", 16'(CHK_ERR), 16'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("lock.idle", 16'(BUSY), 16'd0);

    // ---------------- false sync, then reset mid-frame ----------------
    $display("[TB] false sync and reset mid-frame");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b0);
    tick();
    checkOutput("fsync.no_vld1", 16'(rxBus.DOUT_VLD), 16'd0);
    tick();
    checkOutput("fsync.no_vld2", 16'(rxBus.DOUT_VLD), 16'd0);
    for (int k = 0; k < 50; k++) begin
      logic [7:0] b;
      b = 8'(8'h3C + k);
      applyStimulus(1'b1, b, ~b, 1'b0);
      tick();
      if (k == 0) checkBeat("fsync.sof", 16'h3CC3, 1'b1, 1'b0);
    end
    checkBeat("fsync.held", 16'h3CC3, 1'b1, 1'b0);
    checkOutput("fsync.ovf", 16'(OVF), 16'd1);
    checkOutput("fsync.frm", FRM_CNT, 16'd1);
    RST = 1'b1;
    applyStimulus(1'b0, 8'h6E, 8'h91, 1'b1);
    tick();
    checkOutput("rstmid.vld", 16'(rxBus.DOUT_VLD), 16'd0);
    checkOutput("rstmid.busy", 16'(BUSY), 16'd0);
    checkOutput("rstmid.frm", FRM_CNT, 16'd0);
    checkOutput("rstmid.ovf", 16'(OVF), 16'd0);
    checkOutput("rstmid.dout", rxBus.DOUT, 16'h0000);
    RST = 1'b0;
    tick();
    tick();
    checkOutput("rstmid.no_residual", 16'(rxBus.DOUT_VLD), 16'd0);

    // ---------------- backpressure, RDY=0 for the whole frame ----------------
    $display("[TB] backpressure");
    armAndLock(1'b0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = 8'(k);
      applyStimulus(1'b1, b, ~b, 1'b0);
      tick();
      checkOutput("bp.ovf", 16'(OVF), 16'(k >= 8));
      checkBeat("bp.head", 16'h00FF, 1'b1, 1'b0);
    end
    checkOutput("bp.frm", FRM_CNT, 16'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    checkOutput("bp.idle", 16'(BUSY), 16'd0);
    checkOutput("bp.ovf_sticky", 16'(OVF), 16'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      checkBeat("bp.drain", {b, ~b}, i == 0, 1'b0);
      tick();
    end
    checkOutput("bp.empty", 16'(rxBus.DOUT_VLD), 16'd0);

    // ---------------- EN drop at beat 100, bad checksum byte ----------------
    $display("[TB] EN drop mid-frame");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("endrop.ovf_cleared", 16'(OVF), 16'd0);
    checkOutput("endrop.busy", 16'(BUSY), 16'd1);
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = (k == 255) ? 8'h00 : 8'(k);
      applyStimulus(k < 100, b, ~b, 1'b1);
      tick();
      checkBeat("endrop.beat", {b, ~b}, k == 0, k == 255);
      if (k == 150) checkOutput("endrop.busy_mid", 16'(BUSY), 16'd1);
    end
    checkOutput("endrop.frm", FRM_CNT, 16'd2);
    checkOutput("endrop.idle", 16'(BUSY), 16'd0);
    checkOutput("endrop.chk_bad", 16'(CHK_ERR), 16'(EXP_BAD_CHK));
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("endrop.chk_pulse_end", 16'(CHK_ERR), 16'd0);
    checkOutput("endrop.drained", 16'(rxBus.DOUT_VLD), 16'd0);
    checkOutput("endrop.still_idle", 16'(BUSY), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
